// File: rtl/wb_pipelined_ram_slave_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Wishbone RAM slave.
// The response record is split: control bits live here, data width is set per instance.
package wb_pipelined_ram_slave_pkg;

    typedef struct packed {
        logic valid;
        logic err;
    } t_resp_ctrl;

    function automatic int unsigned f_clog2(input int unsigned n);
        int unsigned r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

    function automatic bit f_is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    // Rejects configurations the address slicing and counters cannot represent.
    function automatic bit f_params_ok(input int unsigned addr_w, input int unsigned data_w,
                                       input int unsigned size_w, input int unsigned lat,
                                       input int unsigned max_out);
        return (data_w >= 8) && (data_w % 8 == 0) && f_is_pow2(data_w / 8)
            && (size_w >= 2) && f_is_pow2(size_w)
            && (lat >= 1) && (lat <= 8)
            && (max_out >= 1) && (max_out <= 8)
            && (addr_w > f_clog2(size_w) + f_clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/wb_resp_delay_line.sv
// Fixed-latency shift register of response records with synchronous flush.
// The tail stage is the retiring response.
module wb_resp_delay_line
    import wb_pipelined_ram_slave_pkg::*;
#(
    parameter int unsigned g_latency    = 2,
    parameter int unsigned g_data_width = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    input  logic                    push_valid_i,
    input  logic                    push_err_i,
    input  logic [g_data_width-1:0] push_data_i,
    output logic                    retire_o,
    output logic                    retire_err_o,
    output logic [g_data_width-1:0] retire_data_o
);

    t_resp_ctrl              ctrl_q [g_latency];
    t_resp_ctrl              ctrl_d [g_latency];
    logic [g_data_width-1:0] data_q [g_latency];
    logic [g_data_width-1:0] data_d [g_latency];

    always_comb begin
        ctrl_d[0].valid = push_valid_i;
        ctrl_d[0].err   = push_err_i;
        data_d[0]       = push_data_i;
        for (int unsigned i = 1; i < g_latency; i++) begin
            ctrl_d[i] = ctrl_q[i-1];
            data_d[i] = data_q[i-1];
        end
        if (flush_i) begin
            for (int unsigned i = 0; i < g_latency; i++) begin
                ctrl_d[i] = '0;
                data_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < g_latency; i++) begin
                ctrl_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < g_latency; i++) begin
                ctrl_q[i] <= ctrl_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign retire_o      = ctrl_q[g_latency-1].valid;
    assign retire_err_o  = ctrl_q[g_latency-1].err;
    assign retire_data_o = data_q[g_latency-1];

endmodule

// File: rtl/wb_pipelined_ram_slave.sv
// Pipelined Wishbone B4 slave over a word RAM: fixed ack latency, bounded
// outstanding requests, err for out-of-range addresses, external stall hook.
module wb_pipelined_ram_slave
    import wb_pipelined_ram_slave_pkg::*;
#(
    parameter int unsigned g_addr_width      = 32,
    parameter int unsigned g_data_width      = 32,
    parameter int unsigned g_size_words      = 256,
    parameter int unsigned g_latency         = 2,
    parameter int unsigned g_max_outstanding = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [g_data_width/8-1:0] wb_sel_i,
    input  logic [g_addr_width-1:0]   wb_adr_i,
    input  logic [g_data_width-1:0]   wb_dat_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      wb_rty_o,
    output logic                      wb_stall_o,
    output logic [g_data_width-1:0]   wb_dat_o,
    input  logic                      stall_inject_i
);

    localparam int unsigned c_sel_w = g_data_width / 8;
    localparam int unsigned c_off_w = f_clog2(c_sel_w);
    localparam int unsigned c_idx_w = f_clog2(g_size_words);
    localparam int unsigned c_cnt_w = f_clog2(g_max_outstanding + 1);

    if (!f_params_ok(g_addr_width, g_data_width, g_size_words, g_latency, g_max_outstanding)) begin : g_bad_params
        $error("wb_pipelined_ram_slave: illegal parameter combination");
    end

    logic [g_data_width-1:0] mem [g_size_words];

    logic [c_idx_w-1:0]      word_idx;
    logic                    out_of_range;
    logic                    accept;
    logic                    do_write;
    logic                    retire;
    logic                    line_valid;
    logic                    line_err;
    logic [g_data_width-1:0] line_data;
    logic [g_data_width-1:0] push_data;
    logic [c_cnt_w-1:0]      count_q;
    logic [c_cnt_w-1:0]      count_d;
    logic                    unused_adr;

    assign word_idx     = wb_adr_i[c_off_w +: c_idx_w];
    assign out_of_range = |wb_adr_i[g_addr_width-1 : c_off_w + c_idx_w];
    assign unused_adr   = ^wb_adr_i;

    // Dropping cyc abandons the transfer, so the tail response is suppressed
    // in that same cycle and does not count as a retire.
    assign retire     = line_valid & wb_cyc_i;
    assign wb_stall_o = stall_inject_i
                      | ((count_q == c_cnt_w'(g_max_outstanding)) & ~retire);
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign do_write   = accept & wb_we_i & ~out_of_range;

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int unsigned i = 0; i < c_sel_w; i++) begin
                if (wb_sel_i[i]) mem[word_idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        push_data = '0;
        if (accept && !wb_we_i && !out_of_range) push_data = mem[word_idx];
    end

    wb_resp_delay_line #(
        .g_latency    (g_latency),
        .g_data_width (g_data_width)
    ) u_delay_line (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .flush_i       (~wb_cyc_i),
        .push_valid_i  (accept),
        .push_err_i    (out_of_range),
        .push_data_i   (push_data),
        .retire_o      (line_valid),
        .retire_err_o  (line_err),
        .retire_data_o (line_data)
    );

    always_comb begin
        count_d = count_q;
        if (!wb_cyc_i) begin
            count_d = '0;
        end else if (accept && !retire) begin
            count_d = count_q + 1'b1;
        end else if (!accept && retire) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) count_q <= '0;
        else          count_q <= count_d;
    end

    assign wb_ack_o = retire & ~line_err;
    assign wb_err_o = retire & line_err;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = wb_ack_o ? line_data : '0;

endmodule
